// File: rtl/nvdla_dma_wr_pkg.sv
// Shared definitions for the SDP write-DMA packet stream: field positions,
// beat geometry and the responder FSM states.
package nvdla_dma_wr_pkg;

   localparam int PKT_W        = 515;
   localparam int PKT_TYPE_BIT = 514;

   localparam int CMD_ADDR_LSB = 0;
   localparam int CMD_ADDR_MSB = 63;
   localparam int CMD_SIZE_LSB = 64;
   localparam int CMD_SIZE_MSB = 76;
   localparam int CMD_ACK_BIT  = 77;
   localparam int CMD_SIZE_W   = CMD_SIZE_MSB - CMD_SIZE_LSB + 1;

   localparam int DAT_DATA_LSB = 0;
   localparam int DAT_DATA_MSB = 511;
   localparam int DAT_MASK_LSB = 512;
   localparam int DAT_MASK_MSB = 513;
   localparam int DAT_W        = DAT_DATA_MSB - DAT_DATA_LSB + 1;

   localparam int BEAT_BYTES   = 64;
   localparam int BEAT_SHIFT   = $clog2(BEAT_BYTES);

   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   typedef enum logic {
      IDLE = 1'b0,
      DATA = 1'b1
   } wr_state_e;

   // Only the closing beat of an odd-atom burst carries a single 32B atom.
   function automatic logic [1:0] beat_req_mask(input logic last_beat, input logic odd_atoms);
      return (last_beat && odd_atoms) ? 2'b01 : 2'b11;
   endfunction

endpackage

// File: rtl/nvdla_wr_ack_delay.sv
// Fixed-latency ack delay line: a pulse on ack_in reappears on ack_out
// ACK_LATENCY cycles later; synchronous clear drops everything in flight.
module nvdla_wr_ack_delay #(
   parameter int ACK_LATENCY = 4
) (
   input  logic nvdla_core_clk,
   input  logic nvdla_core_rst,
   input  logic ack_in,
   output logic ack_out
);

   logic [ACK_LATENCY-1:0] dly_q;

   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         dly_q <= '0;
      end else begin
         dly_q <= (dly_q << 1) | ACK_LATENCY'(ack_in);
      end
   end

   assign ack_out = dly_q[ACK_LATENCY-1];

endmodule

// File: rtl/nvdla_mcif_wr_responder.sv
// Memory-side responder for the SDP write-DMA cmd/data packet stream.
// Optional LFSR backpressure on wr_req_ready: define NVDLA_WR_RSP_BACKPRESSURE_EN.
module nvdla_mcif_wr_responder
   import nvdla_dma_wr_pkg::*;
#(
   parameter int ACK_LATENCY = 4,
   parameter int ADDR_W      = 64
) (
   input  logic              nvdla_core_clk,
   input  logic              nvdla_core_rst,
   input  logic              wr_req_valid,
   output logic              wr_req_ready,
   input  logic [PKT_W-1:0]  wr_req_pd,
   output logic              wr_rsp_complete,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [DAT_W-1:0]  mem_wr_data,
   output logic [1:0]        mem_wr_mask,
   output logic              proto_err,
   output logic [31:0]       cmd_cnt,
   output logic [31:0]       beat_cnt
);

   wr_state_e               state_q;
   wr_state_e               state_d;

   logic [ADDR_W-1:0]       base_q;
   logic                    atoms_odd_q;
   logic [CMD_SIZE_W-1:0]   beats_left_q;
   logic [CMD_SIZE_W-2:0]   beat_idx_q;
   logic                    ack_q;

   logic                    xfer;
   logic                    is_data;
   logic                    cmd_take;
   logic                    beat_take;
   logic                    stray_pkt;
   logic                    last_beat;
   logic                    mask_bad;
   logic                    ack_inject;
   logic [1:0]              pkt_mask;
   logic [CMD_SIZE_W-1:0]   pkt_size;
   logic [CMD_SIZE_W-1:0]   beats_init;
   logic [ADDR_W-1:0]       beat_addr;

   // Packet decode and handshake qualification
   assign xfer       = wr_req_valid & wr_req_ready;
   assign is_data    = wr_req_pd[PKT_TYPE_BIT];
   assign pkt_mask   = wr_req_pd[DAT_MASK_MSB:DAT_MASK_LSB];
   assign pkt_size   = wr_req_pd[CMD_SIZE_MSB:CMD_SIZE_LSB];
   // ceil((size+1)/2) without a wider adder
   assign beats_init = {1'b0, pkt_size[CMD_SIZE_W-1:1]} + CMD_SIZE_W'(1);

   assign cmd_take   = xfer & ~is_data & (state_q == IDLE);
   assign beat_take  = xfer &  is_data & (state_q == DATA);
   assign stray_pkt  = xfer & (( is_data & (state_q == IDLE)) |
                               (~is_data & (state_q == DATA)));

   assign last_beat  = (beats_left_q == CMD_SIZE_W'(1));
   assign mask_bad   = beat_take & (pkt_mask != beat_req_mask(last_beat, atoms_odd_q));
   assign ack_inject = beat_take & last_beat & ack_q;
   assign beat_addr  = base_q + (ADDR_W'(beat_idx_q) << BEAT_SHIFT);

   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cmd_take) state_d = DATA;
         DATA:    if (beat_take && last_beat) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Burst context is only consulted in DATA, so it is loaded without reset.
   always_ff @(posedge nvdla_core_clk) begin
      if (cmd_take) begin
         base_q       <= ADDR_W'(wr_req_pd[CMD_ADDR_MSB:CMD_ADDR_LSB]);
         atoms_odd_q  <= ~pkt_size[0];
         beats_left_q <= beats_init;
         beat_idx_q   <= '0;
         ack_q        <= wr_req_pd[CMD_ACK_BIT];
      end else if (beat_take) begin
         beats_left_q <= beats_left_q - CMD_SIZE_W'(1);
         beat_idx_q   <= beat_idx_q + 1'b1;
      end
   end

   // Backing-store write port, one cycle behind the data handshake
   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         mem_wr_en   <= 1'b0;
         mem_wr_addr <= '0;
         mem_wr_data <= '0;
         mem_wr_mask <= '0;
      end else begin
         mem_wr_en <= beat_take;
         if (beat_take) begin
            mem_wr_addr <= beat_addr;
            mem_wr_data <= wr_req_pd[DAT_DATA_MSB:DAT_DATA_LSB];
            mem_wr_mask <= pkt_mask;
         end
      end
   end

   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         proto_err <= 1'b0;
         cmd_cnt   <= '0;
         beat_cnt  <= '0;
      end else begin
         proto_err <= proto_err | stray_pkt | mask_bad;
         if (cmd_take)  cmd_cnt  <= cmd_cnt + 32'd1;
         if (beat_take) beat_cnt <= beat_cnt + 32'd1;
      end
   end

   nvdla_wr_ack_delay #(
      .ACK_LATENCY (ACK_LATENCY)
   ) u_ack_delay (
      .nvdla_core_clk (nvdla_core_clk),
      .nvdla_core_rst (nvdla_core_rst),
      .ack_in         (ack_inject),
      .ack_out        (wr_rsp_complete)
   );

`ifdef NVDLA_WR_RSP_BACKPRESSURE_EN
   logic [15:0] lfsr_q;
   logic        lfsr_fb;

   // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting toward bit 0
   assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
      end
   end

   assign wr_req_ready = ~nvdla_core_rst & (lfsr_q[1:0] != 2'b00);
`else
   assign wr_req_ready = ~nvdla_core_rst;
`endif

endmodule

// File: tb/tb_nvdla_mcif_wr_responder.sv
// Randomized bench for nvdla_mcif_wr_responder with a burst-level reference
// model and a per-cycle compare process.
module tb_nvdla_mcif_wr_responder;

   localparam int LAT = 4;
   localparam int AW  = 64;

   typedef struct {
      int           tag;
      logic [63:0]  addr;
      logic [511:0] data;
      logic [1:0]   mask;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_req_valid = 1'b0;
   logic [514:0]  wr_req_pd = '0;
   logic          wr_req_ready;
   logic          wr_rsp_complete;
   logic          mem_wr_en;
   logic [AW-1:0] mem_wr_addr;
   logic [511:0]  mem_wr_data;
   logic [1:0]    mem_wr_mask;
   logic          proto_err;
   logic [31:0]   cmd_cnt;
   logic [31:0]   beat_cnt;

   always #5 clk = ~clk;

   nvdla_mcif_wr_responder #(
      .ACK_LATENCY (LAT),
      .ADDR_W      (AW)
   ) dut (
      .nvdla_core_clk  (clk),
      .nvdla_core_rst  (rst),
      .wr_req_valid    (wr_req_valid),
      .wr_req_ready    (wr_req_ready),
      .wr_req_pd       (wr_req_pd),
      .wr_rsp_complete (wr_rsp_complete),
      .mem_wr_en       (mem_wr_en),
      .mem_wr_addr     (mem_wr_addr),
      .mem_wr_data     (mem_wr_data),
      .mem_wr_mask     (mem_wr_mask),
      .proto_err       (proto_err),
      .cmd_cnt         (cmd_cnt),
      .beat_cnt        (beat_cnt)
   );

   int vec = 0;
   int bad = 0;
   int ecnt = 0;
   bit started = 0;
   int pulses = 0;

   // reference model state
   bit          m_busy;
   logic [63:0] m_base;
   int          m_atoms, m_beats, m_idx;
   bit          m_ack;
   bit          m_perr;
   logic [31:0] m_cmd, m_beat;
   wr_t         wq[$];
   int          aq[$];
   logic [63:0] wlog[$];

   always @(posedge clk) ecnt <= ecnt + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vec++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, ecnt);
      end
   endtask

   task automatic chkw(input string nm, input logic [511:0] act, input logic [511:0] exp);
      vec++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, ecnt);
      end
   endtask

   function automatic logic [511:0] rand512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [514:0] mk_cmd(input logic [63:0] a, input int size, input bit ack);
      logic [514:0] p;
      p = '0;
      p[63:0]  = a;
      p[76:64] = 13'(size);
      p[77]    = ack;
      return p;
   endfunction

   function automatic logic [514:0] mk_dat(input logic [511:0] d, input logic [1:0] m);
      logic [514:0] p;
      p = '0;
      p[511:0]   = d;
      p[513:512] = m;
      p[514]     = 1'b1;
      return p;
   endfunction

   task automatic model_clear();
      m_busy = 0; m_perr = 0; m_cmd = '0; m_beat = '0;
      wq.delete(); aq.delete();
   endtask

   // Called just after the edge at which pd was accepted (edge index ecnt-1).
   task automatic model_pkt(input logic [514:0] pd);
      wr_t w;
      bit last;
      logic [1:0] req;
      if (!pd[514]) begin
         if (!m_busy) begin
            m_cmd++;
            m_busy  = 1;
            m_base  = pd[63:0];
            m_atoms = int'(pd[76:64]) + 1;
            m_beats = (m_atoms + 1) / 2;
            m_idx   = 0;
            m_ack   = pd[77];
         end else begin
            m_perr = 1;
         end
      end else if (!m_busy) begin
         m_perr = 1;
      end else begin
         last = (m_idx == m_beats - 1);
         req  = (last && (m_atoms % 2 == 1)) ? 2'b01 : 2'b11;
         if (pd[513:512] != req) m_perr = 1;
         w.tag  = ecnt;
         w.addr = m_base + 64'(m_idx) * 64'd64;
         w.data = pd[511:0];
         w.mask = pd[513:512];
         wq.push_back(w);
         m_beat++;
         m_idx++;
         if (last) begin
            m_busy = 0;
            if (m_ack) aq.push_back(ecnt - 1 + LAT);
         end
      end
   endtask

   task automatic send(input logic [514:0] pd);
      bit done = 0;
      bit r;
      wr_req_valid = 1'b1;
      wr_req_pd    = pd;
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge clk);
         r = wr_req_ready;
         @(posedge clk);
         #1;
         if (r) begin
            done = 1;
            model_pkt(pd);
         end
      end
      chk("handshake", 64'(done), 64'h1);
      wr_req_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      @(posedge clk);
      #1;
      model_clear();
      started = 1;
      @(negedge clk);
      chk("rst_wr_en", 64'(mem_wr_en), 64'h0);
      chk("rst_wr_addr", mem_wr_addr, 64'h0);
      chkw("rst_wr_data", mem_wr_data, 512'h0);
      chk("rst_wr_mask", 64'(mem_wr_mask), 64'h0);
      chk("rst_complete", 64'(wr_rsp_complete), 64'h0);
      chk("rst_perr", 64'(proto_err), 64'h0);
      chk("rst_cmd_cnt", 64'(cmd_cnt), 64'h0);
      chk("rst_beat_cnt", 64'(beat_cnt), 64'h0);
      chk("rst_ready", 64'(wr_req_ready), 64'h0);
      idle(n);
      rst = 1'b0;
   endtask

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (started) begin
         if (wq.size() > 0 && wq[0].tag == ecnt) begin
            chk("wr_en", 64'(mem_wr_en), 64'h1);
            chk("wr_addr", mem_wr_addr, wq[0].addr);
            chkw("wr_data", mem_wr_data, wq[0].data);
            chk("wr_mask", 64'(mem_wr_mask), 64'(wq[0].mask));
            void'(wq.pop_front());
         end else begin
            chk("wr_en", 64'(mem_wr_en), 64'h0);
         end
         if (mem_wr_en) wlog.push_back(mem_wr_addr);
         if (aq.size() > 0 && aq[0] == ecnt) begin
            chk("complete", 64'(wr_rsp_complete), 64'h1);
            void'(aq.pop_front());
         end else begin
            chk("complete", 64'(wr_rsp_complete), 64'h0);
         end
         if (wr_rsp_complete) pulses++;
         chk("proto_err", 64'(proto_err), 64'(m_perr));
         chk("cmd_cnt", 64'(cmd_cnt), 64'(m_cmd));
         chk("beat_cnt", 64'(beat_cnt), 64'(m_beat));
`ifdef NVDLA_WR_RSP_BACKPRESSURE_EN
         if (rst) chk("ready", 64'(wr_req_ready), 64'h0);
`else
         chk("ready", 64'(wr_req_ready), 64'(!rst));
`endif
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int e2, tag2, p0;
      logic [31:0] b0;
      @(posedge clk);
      #1;
      do_reset(2);

      // basic acked burst: 4 atoms -> 2 full beats
      wlog.delete();
      send(mk_cmd(64'h1000, 3, 1'b1));
      send(mk_dat(rand512(), 2'b11));
      send(mk_dat(rand512(), 2'b11));
      e2 = ecnt - 1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (ecnt == e2 + 3) chk("t1_no_early_ack", 64'(wr_rsp_complete), 64'h0);
      end
      chk("t1_ack_at_4", 64'(wr_rsp_complete), 64'h1);
      chk("t1_cmd_cnt", 64'(cmd_cnt), 64'h1);
      chk("t1_beat_cnt", 64'(beat_cnt), 64'h2);
      chk("t1_nwrites", 64'(wlog.size()), 64'h2);
      if (wlog.size() == 2) begin
         chk("t1_addr0", wlog[0], 64'h1000);
         chk("t1_addr1", wlog[1], 64'h1040);
      end
      @(posedge clk);
      #1;

      // single-atom, no ack
      p0 = pulses;
      send(mk_cmd(64'h2000, 0, 1'b0));
      send(mk_dat(rand512(), 2'b01));
      idle(LAT + 3);
      chk("t2_perr", 64'(proto_err), 64'h0);
      chk("t2_no_ack", 64'(pulses), 64'(p0));

      // wrong final-beat mask on an odd-atom burst
      send(mk_cmd(64'h3000, 2, 1'b1));
      send(mk_dat(rand512(), 2'b11));
      send(mk_dat(rand512(), 2'b11));
      idle(LAT + 3);
      chk("t3_perr", 64'(proto_err), 64'h1);
      send(mk_cmd(64'h3100, 1, 1'b0));
      send(mk_dat(rand512(), 2'b11));
      idle(3);
      chk("t3_perr_sticky", 64'(proto_err), 64'h1);

      // stray data in IDLE, stray cmd in DATA
      do_reset(2);
      wlog.delete();
      send(mk_dat(rand512(), 2'b11));
      send(mk_cmd(64'h4000, 1, 1'b0));
      send(mk_cmd(64'h5000, 5, 1'b1));
      send(mk_dat(rand512(), 2'b11));
      idle(3);
      chk("t4_cmd_cnt", 64'(cmd_cnt), 64'h1);
      chk("t4_beat_cnt", 64'(beat_cnt), 64'h1);
      chk("t4_perr", 64'(proto_err), 64'h1);
      chk("t4_nwrites", 64'(wlog.size()), 64'h1);
      if (wlog.size() == 1) chk("t4_addr", wlog[0], 64'h4000);

      // three acked single-beat bursts, reset during the second pulse
      do_reset(2);
      p0 = pulses;
      tag2 = 0;
      for (int i = 0; i < 3; i++) begin
         send(mk_cmd(64'h6000 + 64'(i) * 64'h40, 1, 1'b1));
         send(mk_dat(rand512(), 2'b11));
         if (i == 1) tag2 = ecnt - 1 + LAT;
      end
      while (ecnt < tag2) begin
         @(posedge clk);
         #1;
      end
      do_reset(3);
      idle(LAT + 4);
      chk("t5_pulses", 64'(pulses - p0), 64'h2);
      send(mk_cmd(64'h7000, 0, 1'b0));
      send(mk_dat(rand512(), 2'b01));
      idle(2);
      chk("t5_idle_after_rst", 64'(proto_err), 64'h0);
      chk("t5_cmd_cnt", 64'(cmd_cnt), 64'h1);

      // maximum burst: 8192 atoms, 4096 beats
      wlog.delete();
      b0 = beat_cnt;
      send(mk_cmd(64'h0010_0000, 8191, 1'b1));
      for (int i = 0; i < 4096; i++) send(mk_dat(rand512(), 2'b11));
      idle(LAT + 3);
      chk("t6_nwrites", 64'(wlog.size()), 64'd4096);
      if (wlog.size() == 4096) begin
         chk("t6_first", wlog[0], 64'h0010_0000);
         chk("t6_last", wlog[4095], 64'h0013_FFC0);
      end
      chk("t6_beats", 64'(beat_cnt - b0), 64'd4096);
      chk("t6_perr", 64'(proto_err), 64'h0);

      // randomized traffic, including protocol errors and address wrap
      do_reset(2);
      for (int n = 0; n < 60; n++) begin
         int size, atoms, beats;
         logic [63:0] a;
         logic [1:0] req, m;
         if ($urandom_range(0, 9) == 0) begin
            send(mk_dat(rand512(), 2'($urandom)));
         end else begin
            size  = $urandom_range(0, 6);
            atoms = size + 1;
            beats = (atoms + 1) / 2;
            a = (n == 7) ? 64'hFFFF_FFFF_FFFF_FFC0 : {$urandom, $urandom};
            send(mk_cmd(a, size, 1'($urandom)));
            for (int b = 0; b < beats; b++) begin
               if ($urandom_range(0, 9) == 0) send(mk_cmd({$urandom, $urandom}, 3, 1'b1));
               req = (b == beats - 1 && atoms % 2 == 1) ? 2'b01 : 2'b11;
               m = ($urandom_range(0, 7) == 0) ? (req ^ 2'($urandom_range(1, 3))) : req;
               send(mk_dat(rand512(), m));
               idle($urandom_range(0, 2));
            end
         end
         idle($urandom_range(0, 3));
      end
      idle(LAT + 4);

      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

endmodule

// File: doc/nvdla_mcif_wr_responder.md
Name: nvdla_mcif_wr_responder

Overview:
- Memory-side responder for the SDP DMA write-request interface: consumes the 515-bit cmd/data packet stream, drives a flat backing-store write port, and returns the write-complete pulse for commands that request an ack.
- Sits where MCIF/CVIF would sit.
- Used as the sink for SDP write-DMA traffic in subsystem benches and in FPGA bring-up builds.

Parameters:
- ACK_LATENCY, 4, cycles from last-beat handshake to wr_rsp_complete pulse; legal range 1..32.
- ADDR_W, 64, width of command address and mem_wr_addr.

Ports:
- nvdla_core_clk  in  1  core clock
- nvdla_core_rst  in  1  synchronous reset, active-high
- wr_req_valid  in  1  packet valid
- wr_req_ready  out  1  packet ready
- wr_req_pd  in  515  packet; [514]=pkt type (0 cmd, 1 data)
  - cmd: [63:0] byte addr, [76:64] size (32B atoms minus 1), [77] require_ack
  - data: [511:0] data, [513:512] atom mask
- wr_rsp_complete  out  1  one-cycle ack pulse
- mem_wr_en  out  1  write strobe
- mem_wr_addr  out  ADDR_W  byte address of the 64B beat
- mem_wr_data  out  512  beat data
- mem_wr_mask  out  2  atom enables; [0]=low 32B, [1]=high 32B
- proto_err  out  1  sticky protocol error
- cmd_cnt  out  32  accepted well-formed commands
- beat_cnt  out  32  data beats written

Behaviour:
- Handshake: a transfer occurs when wr_req_valid & wr_req_ready. pd is sampled only on a transfer.
- wr_req_ready is 1 whenever not in reset; it is gated only by the optional feature.
- FSM, IDLE state:
  - cmd transfer: latch base=addr, atoms=size+1, beats_left=ceil(atoms/2), ack=require_ack, beat_idx=0; go to DATA.
  - data transfer: discard the packet, set proto_err.
- FSM, DATA state, data transfer:
  - Register mem_wr_en=1, mem_wr_addr=base+64*beat_idx (ADDR_W-bit wrap), mem_wr_data, mem_wr_mask = pd mask. Outputs appear the cycle after the transfer.
  - Increment beat_cnt. Decrement beats_left; increment beat_idx.
  - Required mask: 2'b11, except the final beat when atoms is odd, which must be 2'b01. On mismatch: set proto_err; the write still happens with the received mask.
  - On the final beat: return to IDLE; if ack=1, inject a 1 into the ack delay line.
- FSM, DATA state, cmd transfer: discard the packet, set proto_err, stay in DATA.
- cmd_cnt increments on each cmd accepted in IDLE. Both counters wrap at 2^32.
- Ack delay line: ACK_LATENCY-deep shift register, shifted every cycle; wr_rsp_complete = its output bit.
  - An ack injected at cycle t pulses at cycle t+ACK_LATENCY.
  - Back-to-back acks produce back-to-back pulses; no outstanding limit.
- Boundaries:
  - size=0: 1 beat, mask 01.
  - size=1: 1 beat, mask 11.
  - size=8191: 4096 beats.
  - A cmd accepted in the same cycle that a last-beat ack is injected is legal.
- Reset (any time, including mid-burst):
  - FSM to IDLE; delay line cleared, so pending acks are lost.
  - mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0, mem_wr_mask=0.
  - proto_err=0, counters=0, wr_rsp_complete=0, wr_req_ready=0 during reset and 1 afterwards.
- proto_err clears only on reset.

Optional Feature:
- Macro NVDLA_WR_RSP_BACKPRESSURE_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - wr_req_ready = ~(lfsr[1:0]==2'b00), i.e. ready about 75% of cycles, independent of packet type or FSM state.
  - Valid must be held by the sender; no data is lost.
- Not defined: no LFSR; ready as above.

Decomposition:
- Package nvdla_dma_wr_pkg holds:
  - pkt field constants: PKT_TYPE_BIT=514, CMD_ADDR_LSB/MSB, CMD_SIZE_LSB=64, CMD_SIZE_MSB=76, CMD_ACK_BIT=77, DAT_MASK_LSB=512.
  - the FSM state enum (IDLE, DATA).
  - BEAT_BYTES=64.
- One sub-module, nvdla_wr_ack_delay: the parameterised ACK_LATENCY shift register with synchronous clear.

Test Plan:
- cmd addr=0x1000, size=3, ack=1, then 2 data beats with mask 11:
  - writes at 0x1000 and 0x1040, each mask 11.
  - wr_rsp_complete pulses exactly 4 cycles after the second beat handshake.
  - cmd_cnt=1, beat_cnt=2.
- cmd size=0, ack=0, 1 beat with mask 01:
  - one write, mask 01, no ack pulse, proto_err=0.
- cmd size=2 with final-beat mask 11 (expected 01):
  - both writes occur, proto_err=1 and stays 1 until reset.
- Data packet while IDLE, then cmd while in DATA:
  - no mem_wr_en for either, proto_err=1, cmd_cnt unchanged by the stray cmd.
- Three 1-beat acked cmds issued back-to-back:
  - three consecutive wr_rsp_complete pulses.
  - Reset asserted during the second pulse: no further pulses, all outputs 0, FSM IDLE.
- With NVDLA_WR_RSP_BACKPRESSURE_EN, size=8191 burst:
  - 4096 writes with contiguous addresses base..base+0x3FFC0.
  - No beat is lost while ready toggles; ack arrives ACK_LATENCY cycles after the last beat.
